// File: rtl/bram_dp_masked_if.sv
// bram_dp_masked_if: access bundle for bram_dp_masked (two RAM ports plus READY/COLL status).
// The master side drives addresses, data, masks and enables; the slave side returns read data
// and status.
interface bram_dp_masked_if #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned ADDR_WIDTH = 11
);
   logic [ADDR_WIDTH-1:0] A0;
   logic [ADDR_WIDTH-1:0] A1;
   logic [DATA_WIDTH-1:0] D0;
   logic [DATA_WIDTH-1:0] D1;
   logic [DATA_WIDTH-1:0] Q0;
   logic [DATA_WIDTH-1:0] Q1;
   logic [DATA_WIDTH-1:0] WEM0;
   logic [DATA_WIDTH-1:0] WEM1;
   logic                  WE0;
   logic                  WE1;
   logic                  CE0;
   logic                  CE1;
   logic                  READY;
   logic                  COLL;

   modport master (
      output A0, A1, D0, D1, WEM0, WEM1, WE0, WE1, CE0, CE1,
      input  Q0, Q1, READY, COLL
   );

   modport slave (
      input  A0, A1, D0, D1, WEM0, WEM1, WE0, WE1, CE0, CE1,
      output Q0, Q1, READY, COLL
   );
endinterface

// File: rtl/bram_dp_masked.sv
// bram_dp_masked: true dual-port RAM with per-bit write masks, selectable same-port
// read-during-write (WRITE_MODE 0 = old word, 1 = merged new word), port-0-wins write
// collision merge with a COLL pulse, and a post-reset sweep writing INIT_VALUE everywhere.
// Accesses are ignored until the sweep finishes and READY rises.
// Build option: define BRAM_DP_OUT_REG_EN to add an output register per port (2-cycle reads).
module bram_dp_masked #(
   parameter int unsigned           DATA_WIDTH = 8,
   parameter int unsigned           ADDR_WIDTH = 11,
   parameter int unsigned           WRITE_MODE = 0,
   parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
   input logic             CLK,
   input logic             RST,
   bram_dp_masked_if.slave bus
);
   localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

   typedef enum logic [1:0] {StReset, StClear, StRun} state_e;

   state_e                state_q;
   logic [ADDR_WIDTH-1:0] clr_cnt_q;
   logic                  ready_q;
   logic                  coll_q;
   logic [DATA_WIDTH-1:0] q0_q;
   logic [DATA_WIDTH-1:0] q1_q;
   logic [DATA_WIDTH-1:0] mem [DEPTH];

   logic                  clearing;
   logic                  acc0;
   logic                  acc1;
   logic                  wr0;
   logic                  wr1;
   logic                  coll;
   logic [DATA_WIDTH-1:0] old0;
   logic [DATA_WIDTH-1:0] old1;
   logic [DATA_WIDTH-1:0] new0;
   logic [DATA_WIDTH-1:0] new1;
   logic [DATA_WIDTH-1:0] merged;

   // Access qualification and per-port / collision write-data merging.
   always_comb begin
      // The sweep already acts in the first cycle after reset, so the Reset state counts too.
      clearing = ~RST & (state_q != StRun);
      acc0     = bus.CE0 & ready_q & ~RST;
      acc1     = bus.CE1 & ready_q & ~RST;
      wr0      = acc0 & bus.WE0;
      wr1      = acc1 & bus.WE1;
      coll     = wr0 & wr1 & (bus.A0 == bus.A1);
      old0     = mem[bus.A0];
      old1     = mem[bus.A1];
      new0     = (old0 & ~bus.WEM0) | (bus.D0 & bus.WEM0);
      new1     = (old1 & ~bus.WEM1) | (bus.D1 & bus.WEM1);
      // Port 0 owns every bit it masks in; port 1 only fills bits port 0 leaves alone.
      merged   = (old0 & ~(bus.WEM0 | bus.WEM1)) | (bus.D0 & bus.WEM0)
               | (bus.D1 & bus.WEM1 & ~bus.WEM0);
   end

   // Reset/clear/run sequencer with the sweep address counter and registered READY.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q   <= StReset;
         clr_cnt_q <= '0;
         ready_q   <= 1'b0;
      end else begin
         unique case (state_q)
            StReset, StClear: begin
               clr_cnt_q <= clr_cnt_q + 1'b1;
               if (&clr_cnt_q) begin
                  state_q <= StRun;
                  ready_q <= 1'b1;
               end else begin
                  state_q <= StClear;
               end
            end
            StRun: begin
            end
            default: begin
               state_q <= StReset;
            end
         endcase
      end
   end

   // Memory array: sweep writes, else masked port writes (port 0 assigned last so it wins).
   always_ff @(posedge CLK) begin
      if (clearing) begin
         mem[clr_cnt_q] <= INIT_VALUE;
      end else begin
         if (wr1) begin
            mem[bus.A1] <= new1;
         end
         if (wr0) begin
            mem[bus.A0] <= coll ? merged : new0;
         end
      end
   end

   // First-stage read data and collision flag; Q holds while its port is not accepted.
   always_ff @(posedge CLK) begin
      if (RST) begin
         q0_q   <= '0;
         q1_q   <= '0;
         coll_q <= 1'b0;
      end else begin
         if (acc0) begin
            q0_q <= (bus.WE0 && (WRITE_MODE != 0)) ? new0 : old0;
         end
         if (acc1) begin
            q1_q <= (bus.WE1 && (WRITE_MODE != 0)) ? new1 : old1;
         end
         coll_q <= coll;
      end
   end

`ifdef BRAM_DP_OUT_REG_EN
   logic                  acc0_q;
   logic                  acc1_q;
   logic [DATA_WIDTH-1:0] q0_r;
   logic [DATA_WIDTH-1:0] q1_r;

   // Optional output stage: only reloads when stage 1 was refreshed by an accepted access.
   always_ff @(posedge CLK) begin
      if (RST) begin
         acc0_q <= 1'b0;
         acc1_q <= 1'b0;
         q0_r   <= '0;
         q1_r   <= '0;
      end else begin
         acc0_q <= acc0;
         acc1_q <= acc1;
         if (acc0_q) begin
            q0_r <= q0_q;
         end
         if (acc1_q) begin
            q1_r <= q1_q;
         end
      end
   end

   assign bus.Q0 = q0_r;
   assign bus.Q1 = q1_r;
`else
   assign bus.Q0 = q0_q;
   assign bus.Q1 = q1_q;
`endif

   assign bus.READY = ready_q;
   assign bus.COLL  = coll_q;

endmodule

// File: tb/tb_bram_dp_masked.sv
// tb_bram_dp_masked: directed scoreboard bench. Two DUTs (read-first and write-first) see
// identical stimulus; expected read words for both modes are queued at issue time and a
// monitor pops them when the read latency elapses. COLL is checked every cycle.
module tb_bram_dp_masked;
   localparam int unsigned DW    = 8;
   localparam int unsigned AW    = 4;
   localparam int unsigned DEPTH = 16;
`ifdef BRAM_DP_OUT_REG_EN
   localparam int unsigned LAT = 2;
`else
   localparam int unsigned LAT = 1;
`endif

   typedef struct {
      string         name;
      logic [DW-1:0] rf;
      logic [DW-1:0] wf;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic [AW-1:0] a0 = '0, a1 = '0;
   logic [DW-1:0] d0 = '0, d1 = '0, m0 = '0, m1 = '0;
   logic          we0 = 1'b0, we1 = 1'b0, ce0 = 1'b0, ce1 = 1'b0;

   logic          iss0 = 1'b0, iss1 = 1'b0, iss_coll = 1'b0;
   logic [1:0]    pend0 = '0, pend1 = '0;
   logic          pend_coll = 1'b0;
   exp_t          sb0[$];
   exp_t          sb1[$];
   int            n_chk = 0;
   int            n_fail = 0;

   bram_dp_masked_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus_rf ();
   bram_dp_masked_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus_wf ();

   assign bus_rf.A0 = a0;   assign bus_wf.A0 = a0;
   assign bus_rf.A1 = a1;   assign bus_wf.A1 = a1;
   assign bus_rf.D0 = d0;   assign bus_wf.D0 = d0;
   assign bus_rf.D1 = d1;   assign bus_wf.D1 = d1;
   assign bus_rf.WEM0 = m0; assign bus_wf.WEM0 = m0;
   assign bus_rf.WEM1 = m1; assign bus_wf.WEM1 = m1;
   assign bus_rf.WE0 = we0; assign bus_wf.WE0 = we0;
   assign bus_rf.WE1 = we1; assign bus_wf.WE1 = we1;
   assign bus_rf.CE0 = ce0; assign bus_wf.CE0 = ce0;
   assign bus_rf.CE1 = ce1; assign bus_wf.CE1 = ce1;

   bram_dp_masked #(
      .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .WRITE_MODE(0), .INIT_VALUE(8'hA5)
   ) dut_rf (
      .CLK(clk), .RST(rst), .bus(bus_rf.slave)
   );

   bram_dp_masked #(
      .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .WRITE_MODE(1), .INIT_VALUE(8'hA5)
   ) dut_wf (
      .CLK(clk), .RST(rst), .bus(bus_wf.slave)
   );

   task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Delay the issue markers by the read latency.
   always @(posedge clk) begin
      pend0     <= {pend0[0], iss0};
      pend1     <= {pend1[0], iss1};
      pend_coll <= iss_coll;
   end

   // Monitor: pop and compare when a read result is due; COLL every cycle.
   always @(negedge clk) begin
      exp_t e;
      if (pend0[LAT-1]) begin
         if (sb0.size() == 0) begin
            n_chk++; n_fail++;
            $display("FAIL sb0_underflow: got empty queue, expected an entry");
         end else begin
            e = sb0.pop_front();
            check({e.name, "_q0_rf"}, bus_rf.Q0, e.rf);
            check({e.name, "_q0_wf"}, bus_wf.Q0, e.wf);
         end
      end
      if (pend1[LAT-1]) begin
         if (sb1.size() == 0) begin
            n_chk++; n_fail++;
            $display("FAIL sb1_underflow: got empty queue, expected an entry");
         end else begin
            e = sb1.pop_front();
            check({e.name, "_q1_rf"}, bus_rf.Q1, e.rf);
            check({e.name, "_q1_wf"}, bus_wf.Q1, e.wf);
         end
      end
      check("coll_rf", DW'(bus_rf.COLL), DW'(pend_coll));
      check("coll_wf", DW'(bus_wf.COLL), DW'(pend_coll));
   end

   task automatic step();
      @(posedge clk);
      #1;
      ce0 = 1'b0; ce1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
      iss0 = 1'b0; iss1 = 1'b0; iss_coll = 1'b0;
   endtask

   task automatic p0(input logic we, input int a, input logic [DW-1:0] d, input logic [DW-1:0] m);
      ce0 = 1'b1; we0 = we; a0 = AW'(a); d0 = d; m0 = m;
   endtask

   task automatic p1(input logic we, input int a, input logic [DW-1:0] d, input logic [DW-1:0] m);
      ce1 = 1'b1; we1 = we; a1 = AW'(a); d1 = d; m1 = m;
   endtask

   task automatic e0(input string name, input logic [DW-1:0] rf, input logic [DW-1:0] wf);
      exp_t e;
      e.name = name; e.rf = rf; e.wf = wf;
      sb0.push_back(e);
      iss0 = 1'b1;
   endtask

   task automatic e1(input string name, input logic [DW-1:0] rf, input logic [DW-1:0] wf);
      exp_t e;
      e.name = name; e.rf = rf; e.wf = wf;
      sb1.push_back(e);
      iss1 = 1'b1;
   endtask

   task automatic check_q_zero(input string name);
      check({name, "_q0_rf"}, bus_rf.Q0, '0);
      check({name, "_q1_rf"}, bus_rf.Q1, '0);
      check({name, "_q0_wf"}, bus_wf.Q0, '0);
      check({name, "_q1_wf"}, bus_wf.Q1, '0);
   endtask

   // Release reset and walk the sweep, hammering colliding writes that must be ignored.
   task automatic sweep(input logic [DW-1:0] junk);
      rst = 1'b0;
      for (int i = 0; i <= DEPTH; i++) begin
         check("ready_sweep_rf", DW'(bus_rf.READY), DW'(i == DEPTH));
         check("ready_sweep_wf", DW'(bus_wf.READY), DW'(i == DEPTH));
         if (i < DEPTH) begin
            check_q_zero("sweep");
            p0(1'b1, i, junk, 8'hFF);
            p1(1'b1, i, ~junk, 8'hFF);
            step();
         end
      end
   endtask

   task automatic read_all(input string name);
      for (int i = 0; i < DEPTH; i++) begin
         p0(1'b0, i, '0, '0);         e0(name, 8'hA5, 8'hA5);
         p1(1'b0, DEPTH - 1 - i, '0, '0); e1(name, 8'hA5, 8'hA5);
         step();
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, expected end of test");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(posedge clk);
      #1;
      check("rst_ready_rf", DW'(bus_rf.READY), '0);
      check("rst_ready_wf", DW'(bus_wf.READY), '0);
      check("rst_coll_rf", DW'(bus_rf.COLL), '0);
      check_q_zero("rst");

      sweep(8'h00);
      read_all("clr");

      // Masked write over A5, then cross-port read.
      p0(1'b1, 3, 8'hFF, 8'h0F); e0("mw", 8'hA5, 8'hAF); step();
      p1(1'b0, 3, '0, '0);       e1("mw_rd", 8'hAF, 8'hAF); step();

      // Read-during-write modes and cross-port old-data read.
      p0(1'b1, 5, 8'h11, 8'hFF); e0("pre5", 8'hA5, 8'h11); step();
      p0(1'b1, 5, 8'h22, 8'hFF); e0("rdw5", 8'h11, 8'h22);
      p1(1'b0, 5, '0, '0);       e1("xrd5", 8'h11, 8'h11); step();
      p0(1'b0, 5, '0, '0);       e0("rd5", 8'h22, 8'h22); step();
      p0(1'b1, 5, 8'hFF, 8'h00); e0("wem0", 8'h22, 8'h22); step();
      p1(1'b0, 5, '0, '0);       e1("wem0_rd", 8'h22, 8'h22); step();

      // Collisions at address 7: overlapping, disjoint, and partial masks.
      p0(1'b1, 7, 8'h0F, 8'h0F); e0("c1", 8'hA5, 8'hAF);
      p1(1'b1, 7, 8'hF0, 8'hFF); e1("c1", 8'hA5, 8'hF0); iss_coll = 1'b1; step();
      step();
      p0(1'b0, 7, '0, '0);       e0("c1_rd", 8'hFF, 8'hFF); step();
      p0(1'b1, 7, 8'h00, 8'h0F); e0("c2", 8'hFF, 8'hF0);
      p1(1'b1, 7, 8'h3C, 8'hF0); e1("c2", 8'hFF, 8'h3F); iss_coll = 1'b1; step();
      p1(1'b0, 7, '0, '0);       e1("c2_rd", 8'h30, 8'h30); step();
      p0(1'b1, 7, 8'hFF, 8'h03); e0("c3", 8'h30, 8'h33);
      p1(1'b1, 7, 8'hFF, 8'h0C); e1("c3", 8'h30, 8'h3C); iss_coll = 1'b1; step();
      p0(1'b0, 7, '0, '0);       e0("c3_rd", 8'h3F, 8'h3F); step();

      // Writes to different addresses on both ports: no collision.
      p0(1'b1, 8, 8'h12, 8'hFF); e0("w8", 8'hA5, 8'h12);
      p1(1'b1, 9, 8'h34, 8'hFF); e1("w9", 8'hA5, 8'h34); step();
      p0(1'b0, 9, '0, '0);       e0("rd9", 8'h34, 8'h34);
      p1(1'b0, 8, '0, '0);       e1("rd8", 8'h12, 8'h12); step();

      // CE low: Q holds and a write with CE low is not performed.
      p0(1'b0, 7, '0, '0);       e0("hold_rd", 8'h3F, 8'h3F); step();
      for (int i = 0; i < 3; i++) begin
         we0 = 1'b1; a0 = AW'(7); d0 = 8'h00; m0 = 8'hFF;
         step();
      end
      check("hold_q0_rf", bus_rf.Q0, 8'h3F);
      check("hold_q0_wf", bus_wf.Q0, 8'h3F);
      check("hold_q1_rf", bus_rf.Q1, 8'h12);
      p0(1'b0, 7, '0, '0);       e0("hold_chk", 8'h3F, 8'h3F); step();
      repeat (LAT + 1) step();

      // Mid-sweep reset: abort at sweep address 9, hold 2 cycles, full sweep again.
      rst = 1'b1; step(); step();
      rst = 1'b0;
      repeat (9) step();
      rst = 1'b1; step(); step();
      check("midrst_ready", DW'(bus_rf.READY), '0);
      sweep(8'h5A);
      read_all("clr2");

      repeat (LAT + 2) step();
      check("sb_drain", DW'(sb0.size() + sb1.size()), '0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/bram_dp_masked.md
# bram_dp_masked

Parametrised true-dual-port block RAM with per-bit write masking, selectable read-during-write mode, deterministic write-write collision resolution and a post-reset memory clear sweep. Generalises the fixed 2048x8 dual-port BRAM wrappers in the Virtex-7 tech layer. Sits under the generated memory banks, one instance per physical bank, and gates all accesses until the clear sweep finishes.

## Interface
- DATA_WIDTH, 8, word width in bits (1..72)
- ADDR_WIDTH, 11, address width; DEPTH = 2**ADDR_WIDTH
- WRITE_MODE, 0, same-port read-during-write: 0 = read-first (old word), 1 = write-first (merged new word)
- INIT_VALUE, 0, DATA_WIDTH-bit value written to every word by the clear sweep

Ports:
- CLK  in  1  single clock; all ports synchronous to its rising edge
- RST  in  1  synchronous, active-high reset
- A0 / A1  in  ADDR_WIDTH  port 0 / port 1 address
- D0 / D1  in  DATA_WIDTH  write data
- Q0 / Q1  out  DATA_WIDTH  read data
- WE0 / WE1  in  1  write enable
- WEM0 / WEM1  in  DATA_WIDTH  per-bit write mask, 1 = write bit
- CE0 / CE1  in  1  port enable; port does nothing when low
- READY  out  1  high once clear sweep is done; accesses accepted only when high
- COLL  out  1  one-cycle pulse: write-write collision occurred on the previous accepted cycle

## Operation
- FSM states: RESET, CLEAR, RUN.
  - RESET: entered while RST=1. Clear counter = 0.
  - CLEAR: entered on the first cycle with RST=0. Writes INIT_VALUE to address counter, one word per cycle, counter 0..DEPTH-1. Leaves to RUN after writing DEPTH-1.
  - RUN: normal access. Stays here until RST.
- RST in any state, including mid-sweep, returns to RESET. The sweep restarts from address 0.
- While READY=0, CE0/CE1/WE0/WE1 are ignored. Memory is written only by the sweep, and Q0/Q1 stay 0.
- Accepted access on port p: CEp=1 and READY=1.
- Masked write: bit i of word Ap gets Dp[i] only if WEp & WEMp[i]. WEp=1 with WEMp all zero leaves memory unchanged but is still a write for read-mode purposes.
- Read: every accepted access also reads Ap.
  - WEp=0: Qp = stored word.
  - WEp=1, WRITE_MODE=0: Qp = pre-write word.
  - WEp=1, WRITE_MODE=1: Qp = (old & ~WEMp) | (Dp & WEMp).
- Cross-port read of an address the other port writes in the same cycle returns the old word, in both modes.
- Write-write collision: both ports accepted, WE0=WE1=1, A0==A1.
  - Bits with WEM0=1 take D0.
  - Bits with WEM0=0 and WEM1=1 take D1.
  - Remaining bits are unchanged.
  - COLL=1 on the following cycle. Collision registration does not depend on whether the masks overlap.
  - Each port's Q follows its own WRITE_MODE rule, computed against its own D/WEM only.
- CEp=0: Qp holds its last value.

## Timing
- Reset values: Q0=0, Q1=0, READY=0, COLL=0.
- Clear duration: READY rises exactly DEPTH cycles after the first cycle with RST=0. For ADDR_WIDTH=11, that is 2048 cycles.
- Read latency: 1 cycle, meaning Qp is valid on the edge after the accepted cycle. The build macro below changes this.
- Back-to-back accesses are permitted every cycle on both ports. There is no throughput loss.
- COLL latency matches the base read latency (1 cycle). It is not delayed by the output register.

## Configuration
- BRAM_DP_OUT_REG_EN defined:
  - An extra output register is added per port.
  - Read latency becomes 2 cycles.
  - Register updates only when the stage-1 data was produced by an accepted access. Holding behaviour is preserved.
  - The register resets to 0.
- BRAM_DP_OUT_REG_EN undefined: latency is 1 cycle, as specified above.

## Test plan
- Reset/clear: DATA_WIDTH=8, ADDR_WIDTH=4, INIT_VALUE=8'hA5. Release RST. Expected:
  - READY=0 for 16 cycles, then 1.
  - Reads of addresses 0..15 return 8'hA5.
  - Q stays 0 during the sweep.
- Masked write: write A0=3, D0=8'hFF, WEM0=8'h0F over 8'hA5. Read A1=3 → Q1=8'hAF one cycle later.
- Read modes: pre-load address 5 with 8'h11, then write D0=8'h22, WEM0=8'hFF.
  - WRITE_MODE=0: Q0=8'h11.
  - WRITE_MODE=1: Q0=8'h22.
  - A following read returns 8'h22.
- Collision: same address 7, D0=8'h0F with WEM0=8'h0F, D1=8'hF0 with WEM1=8'hFF. Expected:
  - Word becomes 8'hFF.
  - COLL=1 for exactly one cycle.
  - Repeat with WEM1=8'hF0: COLL still pulses.
- Mid-sweep reset: assert RST at sweep address 9, hold 2 cycles, release. Expected:
  - READY rises exactly DEPTH cycles after release.
  - Accesses during the sweep do not alter memory.
- Macro build: with BRAM_DP_OUT_REG_EN, a read of address 3 returns 8'hAF two cycles after the request. Q holds when CE=0.
